// File: rtl/noc_route_pkg.sv
// Shared route constants, FSM state type and node index helper.
// Used by mc_port_mask and mc_route_fork.
package noc_route_pkg;
  localparam int NPORT   = 5;
  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FORK = 1'b1
  } state_t;

  function automatic int node_idx(
    input int x,
    input int y,
    input int ydim
  );
    return x * ydim + y;
  endfunction
endpackage

// File: rtl/mc_port_mask.sv
// Combinational split of a pending bitmap into per-port sub-bitmaps.
// Define ROUTE_YX_EN for YX order; XY order otherwise.
module mc_port_mask
  import noc_route_pkg::*;
#(
  parameter int XDIM    = 5,
  parameter int YDIM    = 4,
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int NNODE   = XDIM * YDIM
) (
  input  logic [NNODE-1:0]            i_pend,
  output logic [NPORT-1:0][NNODE-1:0] o_mask
);

  localparam int MY_POS = node_idx(MY_XPOS, MY_YPOS, YDIM);

  for (genvar n = 0; n < NNODE; n++) begin : g_node
    localparam int NX = n / YDIM;
    localparam int NY = n % YDIM;
    localparam logic LOC = (n == MY_POS);
`ifdef ROUTE_YX_EN
    localparam logic NTH = (NY < MY_YPOS);
    localparam logic STH = (NY > MY_YPOS);
    localparam logic EST = (NY == MY_YPOS) && (NX > MY_XPOS);
    localparam logic WST = (NY == MY_YPOS) && (NX < MY_XPOS);
`else
    localparam logic EST = (NX > MY_XPOS);
    localparam logic WST = (NX < MY_XPOS);
    localparam logic STH = (NX == MY_XPOS) && (NY > MY_YPOS);
    localparam logic NTH = (NX == MY_XPOS) && (NY < MY_YPOS);
`endif
    assign o_mask[P_LOCAL][n] = i_pend[n] & LOC;
    assign o_mask[P_NORTH][n] = i_pend[n] & NTH;
    assign o_mask[P_EAST][n]  = i_pend[n] & EST;
    assign o_mask[P_SOUTH][n] = i_pend[n] & STH;
    assign o_mask[P_WEST][n]  = i_pend[n] & WST;
  end

endmodule

// File: rtl/mc_route_fork.sv
// Registered unicast/multicast route fork for a mesh input port.
// ROUTE_YX_EN (in mc_port_mask) selects YX instead of XY routing.
module mc_route_fork
  import noc_route_pkg::*;
#(
  parameter int XDIM    = 5,
  parameter int YDIM    = 4,
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0,
  parameter int NNODE   = XDIM * YDIM,
  parameter int AW      = $clog2(NNODE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mc,
  input  logic [AW-1:0]    in_uaddr,
  input  logic [NNODE-1:0] in_maddr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NPORT-1:0] out_port,
  output logic [NNODE-1:0] out_maddr,
  output logic             out_last,
  output logic             drop
);

  state_t r_state, w_state_nxt;
  logic [NNODE-1:0] r_pend, w_pend_nxt;
  logic r_drop, w_drop_nxt;

  logic [NNODE-1:0] w_hdr_bm;
  logic [NNODE-1:0] w_sel_mask;
  logic [NPORT-1:0][NNODE-1:0] w_mask;
  logic [NPORT-1:0] w_nonempty;
  logic [NPORT-1:0] w_sel;
  logic w_last;
  logic w_fork;

  mc_port_mask #(
    .XDIM   (XDIM),
    .YDIM   (YDIM),
    .MY_XPOS(MY_XPOS),
    .MY_YPOS(MY_YPOS),
    .NNODE  (NNODE)
  ) u_mask (
    .i_pend(r_pend),
    .o_mask(w_mask)
  );

  // Lowest-index non-empty port wins; Local therefore goes first.
  always_comb begin
    w_sel_mask = '0;
    for (int p = 0; p < NPORT; p++) begin
      w_nonempty[p] = |w_mask[p];
    end
    w_sel = w_nonempty & (~w_nonempty + NPORT'(1));
    for (int p = 0; p < NPORT; p++) begin
      if (w_sel[p]) w_sel_mask = w_sel_mask | w_mask[p];
    end
    w_last = ((w_nonempty & ~w_sel) == '0);
  end

  // Out-of-range unicast yields an empty bitmap and is dropped.
  always_comb begin
    w_hdr_bm = '0;
    if (in_mc) begin
      w_hdr_bm = in_maddr;
    end else if ({1'b0, in_uaddr} < (AW+1)'(NNODE)) begin
      w_hdr_bm = NNODE'(1) << in_uaddr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_drop_nxt  = 1'b0;
    w_fork      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_hdr_bm == '0) begin
            w_drop_nxt = 1'b1;
          end else begin
            w_pend_nxt  = w_hdr_bm;
            w_state_nxt = S_FORK;
          end
        end
      end
      S_FORK: begin
        w_fork = 1'b1;
        if (out_ready) begin
          w_pend_nxt = r_pend & ~w_sel_mask;
          if (w_last) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = w_fork;
  assign out_port  = w_fork ? w_sel : '0;
  assign out_maddr = w_fork ? w_sel_mask : '0;
  assign out_last  = w_fork & w_last;
  assign drop      = r_drop;

endmodule

// File: tb/tb_mc_route_fork.sv
// Self-checking bench for mc_route_fork at node (1,1) of a 5x4 mesh.
// Directed header cases plus randomized headers against a routing model.
module tb_mc_route_fork;
  localparam int XD  = 5;
  localparam int YD  = 4;
  localparam int MX  = 1;
  localparam int MY  = 1;
  localparam int NN  = XD * YD;
  localparam int AW  = $clog2(NN);
  localparam int NP  = 5;

  typedef logic [NN+8:0] tup_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mc;
  logic [AW-1:0] in_uaddr;
  logic [NN-1:0] in_maddr;
  logic          out_valid;
  logic          out_ready;
  logic [NP-1:0] out_port;
  logic [NN-1:0] out_maddr;
  logic          out_last;
  logic          drop;

  int n_cmp = 0;
  int n_err = 0;

  logic [NP-1:0] q_port[$];
  logic [NN-1:0] q_mask[$];

  mc_route_fork #(
    .XDIM(XD), .YDIM(YD), .MY_XPOS(MX), .MY_YPOS(MY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mc    (in_mc),
    .in_uaddr (in_uaddr),
    .in_maddr (in_maddr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_port (out_port),
    .out_maddr(out_maddr),
    .out_last (out_last),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  function automatic tup_t obs();
    return {out_valid, out_port, out_maddr, out_last, in_ready, drop};
  endfunction

  function automatic tup_t idle_tup();
    return {1'b0, NP'(0), NN'(0), 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic model(input logic [NN-1:0] bm);
    logic [NN-1:0] pm [NP];
    q_port.delete();
    q_mask.delete();
    for (int p = 0; p < NP; p++) pm[p] = '0;
    for (int n = 0; n < NN; n++) begin
      int x, y, p;
      x = n / YD;
      y = n % YD;
      if (bm[n]) begin
        if (x == MX && y == MY) p = 0;
`ifdef ROUTE_YX_EN
        else if (y < MY) p = 1;
        else if (y > MY) p = 3;
        else if (x > MX) p = 2;
        else p = 4;
`else
        else if (x > MX) p = 2;
        else if (x < MX) p = 4;
        else if (y > MY) p = 3;
        else p = 1;
`endif
        pm[p][n] = 1'b1;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (pm[p] != '0) begin
        q_port.push_back(NP'(1) << p);
        q_mask.push_back(pm[p]);
      end
    end
  endtask

  task automatic push_exp(input int p, input logic [NN-1:0] m);
    q_port.push_back(NP'(1) << p);
    q_mask.push_back(m);
  endtask

  // Enter and leave at a falling edge; header accepted on the next rise.
  task automatic run_header(
    input  logic          mc,
    input  logic [AW-1:0] ua,
    input  logic [NN-1:0] ma,
    input  int            pct,
    input  int            st_idx,
    input  int            st_n,
    input  string         nm,
    output int            cyc
  );
    int idx, st;
    tup_t ex, got;
    in_valid = 1'b1;
    in_mc    = mc;
    in_uaddr = ua;
    in_maddr = ma;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: in_ready=%b want 1", nm, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_mc    = 1'($urandom);
    in_uaddr = AW'($urandom);
    in_maddr = NN'($urandom);
    cyc = 0;
    if (q_port.size() == 0) begin
      got = obs();
      ex  = {1'b0, NP'(0), NN'(0), 1'b0, 1'b1, 1'b1};
      n_cmp++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL %s drop: got=%h want=%h", nm, got, ex);
      end
      return;
    end
    idx = 0;
    st  = 0;
    while (idx < q_port.size() && cyc < 200) begin
      if (idx == st_idx && st < st_n) begin
        out_ready = 1'b0;
        st++;
      end else begin
        out_ready = ($urandom_range(99) >= pct);
      end
      got = obs();
      ex  = {1'b1, q_port[idx], q_mask[idx],
             (idx == q_port.size() - 1), 1'b0, 1'b0};
      n_cmp++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL %s req%0d: got=%h want=%h", nm, idx, got, ex);
      end
      @(posedge clk);
      if (out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (idx < q_port.size()) begin
      n_err++;
      $display("FAIL %s timeout: issued=%0d want=%0d", nm, idx, q_port.size());
    end
    got = obs();
    n_cmp++;
    if (got !== idle_tup()) begin
      n_err++;
      $display("FAIL %s idle: got=%h want=%h", nm, got, idle_tup());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_mc = 1'b0;
    in_uaddr = '0;
    in_maddr = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs() !== idle_tup()) begin
      n_err++;
      $display("FAIL reset: got=%h want=%h", obs(), idle_tup());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unicast();
    int c;
    q_port.delete(); q_mask.delete();
    push_exp(2, NN'(20'h02000));
    run_header(1'b0, AW'(13), '0, 0, -1, 0, "uc13", c);
  endtask

  task automatic test_multicast();
    int c;
    q_port.delete(); q_mask.delete();
    push_exp(0, NN'(20'h00020));
    push_exp(2, NN'(20'h02000));
    push_exp(3, NN'(20'h00040));
    push_exp(4, NN'(20'h00001));
    run_header(1'b1, '0, NN'(20'h02061), 0, -1, 0, "mc4", c);
  endtask

  task automatic test_stall();
    int c;
    q_port.delete(); q_mask.delete();
    push_exp(0, NN'(20'h00020));
    push_exp(2, NN'(20'h02000));
    push_exp(3, NN'(20'h00040));
    push_exp(4, NN'(20'h00001));
    run_header(1'b1, '0, NN'(20'h02061), 0, 1, 3, "stall", c);
    n_cmp++;
    if (c !== 7) begin
      n_err++;
      $display("FAIL stall cycles: got=%0d want=7", c);
    end
  endtask

  task automatic test_drop();
    int c;
    q_port.delete(); q_mask.delete();
    run_header(1'b1, '0, '0, 0, -1, 0, "drop_mc0", c);
    q_port.delete(); q_mask.delete();
    run_header(1'b0, AW'(25), '0, 0, -1, 0, "drop_uc25", c);
    @(negedge clk);
    n_cmp++;
    if (obs() !== idle_tup()) begin
      n_err++;
      $display("FAIL drop clear: got=%h want=%h", obs(), idle_tup());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    in_valid = 1'b1;
    in_mc    = 1'b1;
    in_maddr = NN'(20'h02061);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== idle_tup()) begin
      n_err++;
      $display("FAIL rst_mid: got=%h want=%h", obs(), idle_tup());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q_port.delete(); q_mask.delete();
    push_exp(2, NN'(20'h02000));
    run_header(1'b0, AW'(13), '0, 0, -1, 0, "after_rst", c);
  endtask

  task automatic test_route_order();
    int c;
    q_port.delete(); q_mask.delete();
`ifdef ROUTE_YX_EN
    push_exp(1, NN'(20'h01000));
`else
    push_exp(2, NN'(20'h01000));
`endif
    run_header(1'b1, '0, NN'(20'h01000), 0, -1, 0, "bit12", c);
  endtask

  task automatic test_random(input int n, input int pct);
    int c;
    logic mc;
    logic [AW-1:0] ua;
    logic [NN-1:0] ma, bm;
    for (int i = 0; i < n; i++) begin
      mc = 1'($urandom);
      ua = AW'($urandom);
      ma = NN'($urandom);
      if ($urandom_range(1) == 0) ma = ma & NN'($urandom);
      if ($urandom_range(9) == 0) ma = '0;
      if (mc) bm = ma;
      else bm = (int'(ua) < NN) ? (NN'(1) << ua) : '0;
      model(bm);
      run_header(mc, ua, ma, pct, -1, 0, "rand", c);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_stall();
    test_drop();
    test_reset_mid();
    test_route_order();
    test_random(60, 30);
    test_random(30, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
